// File: rtl/rr_skid_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_skid_arbiter
// Purpose  : Four requesters share a single egress stream. A round-robin
//            arbiter feeds a 2-entry output buffer (main + skid). Egress beats
//            appear one cycle after they are pushed, and the buffer sustains
//            one beat per cycle while the egress is ready.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous, active-low reset
//            i_valid_i  - per-requester valid            [3:0]
//            i_data_i   - requester k payload at [k*DATA_W +: DATA_W]
//            i_last_i   - per-requester end-of-packet    [3:0]
//            i_ready_o  - per-requester ready (one-hot or zero)
//            e_ready_i  - egress ready
//            e_valid_o  - egress valid
//            e_data_o   - egress payload
//            e_last_o   - egress end-of-packet
//            e_src_o    - requester index of the current egress beat
// Config   : define RR_ARB_LOCK_EN to keep the grant on one requester from the
//            first beat of a packet until its last beat (packet lock).
// Revision : 1.0 - initial release
// ============================================================================
module rr_skid_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            i_valid_i,
  input  logic [4*DATA_W-1:0]   i_data_i,
  input  logic [3:0]            i_last_i,
  output logic [3:0]            i_ready_o,
  input  logic                  e_ready_i,
  output logic                  e_valid_o,
  output logic [DATA_W-1:0]     e_data_o,
  output logic                  e_last_o,
  output logic [1:0]            e_src_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic [1:0]          r_ptr;
  logic [DATA_W-1:0]   r_main_data;
  logic                r_main_last;
  logic [1:0]          r_main_src;
  logic [DATA_W-1:0]   r_skid_data;
  logic                r_skid_last;
  logic [1:0]          r_skid_src;

  logic                w_any_valid;
  logic                w_accept;
  logic [1:0]          w_rr_grant;
  logic [1:0]          w_grant;
  logic                w_push;
  logic                w_pop;
  logic [DATA_W-1:0]   w_in_data;
  logic                w_in_last;

  assign w_any_valid = |i_valid_i;
  assign w_accept    = (r_state != ST_FULL);

  // First valid requester at or after r_ptr (mod 4). The loop runs from the
  // farthest offset down so the nearest valid requester is written last.
  always_comb begin
    w_rr_grant = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (i_valid_i[r_ptr + 2'(i)]) begin
        w_rr_grant = r_ptr + 2'(i);
      end
    end
  end

`ifdef RR_ARB_LOCK_EN
  logic       r_lock;
  logic [1:0] r_lock_src;

  // While a packet is in flight the grant is pinned to its owner.
  assign w_grant = r_lock ? r_lock_src : w_rr_grant;
`else
  assign w_grant = w_rr_grant;
`endif

  // Ready is a function of buffer state, pointer/lock and valids only, so the
  // egress ready never has a combinational path to the requesters. It is
  // gated by reset so nothing is acknowledged while the block is cleared.
  always_comb begin
    i_ready_o = 4'b0000;
    if (reset && w_any_valid && w_accept) begin
      i_ready_o[w_grant] = 1'b1;
    end
  end

  assign w_in_data = i_data_i[int'(w_grant)*DATA_W +: DATA_W];
  assign w_in_last = i_last_i[w_grant];
  assign w_push    = i_valid_i[w_grant] & i_ready_o[w_grant];
  assign w_pop     = e_valid_o & e_ready_i;

  // Output buffer: main always holds the oldest beat; skid only fills when a
  // push arrives while main is occupied and not leaving.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_last <= 1'b0;
      r_main_src  <= 2'd0;
      r_skid_data <= '0;
      r_skid_last <= 1'b0;
      r_skid_src  <= 2'd0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_state     <= ST_HALF;
            r_main_data <= w_in_data;
            r_main_last <= w_in_last;
            r_main_src  <= w_grant;
          end
        end
        ST_HALF: begin
          if (w_push && !w_pop) begin
            r_state     <= ST_FULL;
            r_skid_data <= w_in_data;
            r_skid_last <= w_in_last;
            r_skid_src  <= w_grant;
          end else if (w_pop && !w_push) begin
            r_state <= ST_EMPTY;
          end else if (w_push && w_pop) begin
            r_main_data <= w_in_data;
            r_main_last <= w_in_last;
            r_main_src  <= w_grant;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_state     <= ST_HALF;
            r_main_data <= r_skid_data;
            r_main_last <= r_skid_last;
            r_main_src  <= r_skid_src;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

  // Round-robin pointer (and packet lock when enabled) only move on a push,
  // so idle cycles and withdrawn valids leave the priority untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= 2'd0;
`ifdef RR_ARB_LOCK_EN
      r_lock     <= 1'b0;
      r_lock_src <= 2'd0;
`endif
    end else if (w_push) begin
`ifdef RR_ARB_LOCK_EN
      if (w_in_last) begin
        r_ptr  <= w_grant + 2'd1;
        r_lock <= 1'b0;
      end else begin
        r_lock     <= 1'b1;
        r_lock_src <= w_grant;
      end
`else
      r_ptr <= w_grant + 2'd1;
`endif
    end
  end

  assign e_valid_o = (r_state != ST_EMPTY);
  assign e_data_o  = r_main_data;
  assign e_last_o  = r_main_last;
  assign e_src_o   = r_main_src;

endmodule
`default_nettype wire

// File: tb/tb_rr_skid_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_skid_arbiter
// Purpose  : Self-checking bench for rr_skid_arbiter. A reference model
//            (occupancy count, priority pointer, optional packet lock) pushes
//            expected beats into a scoreboard queue; an independent monitor
//            pops and compares on every egress handshake. Directed phases
//            cover reset, fairness, backpressure and packet lock, followed by
//            a randomized phase. Honors RR_ARB_LOCK_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_skid_arbiter;

  localparam int DATA_W = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] src;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  i_valid_i = 4'b0;
  logic [31:0] i_data_i = 32'b0;
  logic [3:0]  i_last_i = 4'b0;
  logic [3:0]  i_ready_o;
  logic        e_ready_i = 1'b0;
  logic        e_valid_o;
  logic [7:0]  e_data_o;
  logic        e_last_o;
  logic [1:0]  e_src_o;

  rr_skid_arbiter #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid_i (i_valid_i),
    .i_data_i  (i_data_i),
    .i_last_i  (i_last_i),
    .i_ready_o (i_ready_o),
    .e_ready_i (e_ready_i),
    .e_valid_o (e_valid_o),
    .e_data_o  (e_data_o),
    .e_last_o  (e_last_o),
    .e_src_o   (e_src_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and observation logs.
  beat_t exp_q[$];
  int    obs_src[$];
  int    obs_data[$];
  int    obs_cyc[$];

  // Reference model state.
  int m_cnt = 0;
  int m_ptr = 0;
  bit m_lock = 0;
  int m_lock_src = 0;
  bit m_push = 0;
  int m_g = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, req);
    end
  endtask

  // Model: evaluated mid-cycle with the inputs that will be sampled at the
  // next rising edge.
  always @(negedge clk) begin : p_model
    logic [3:0] exp_rdy;
    int  g;
    bit  found;
    bit  push;
    bit  pop;
    beat_t b;
    if (!reset) begin
      chk("ready_in_reset", {28'b0, i_ready_o}, 32'h0);
      m_cnt = 0; m_ptr = 0; m_lock = 0; m_lock_src = 0;
      m_push = 0;
      exp_q.delete();
    end else begin
      found = 0;
      g = m_ptr;
      if (m_lock) begin
        g = m_lock_src;
        found = (i_valid_i != 4'b0);
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (!found && i_valid_i[(m_ptr + i) % 4]) begin
            g = (m_ptr + i) % 4;
            found = 1;
          end
        end
      end
      exp_rdy = (found && m_cnt < 2) ? (4'b0001 << g) : 4'b0000;
      chk("i_ready", {28'b0, i_ready_o}, {28'b0, exp_rdy});
      push = exp_rdy[g] && i_valid_i[g];
      pop  = (m_cnt > 0) && e_ready_i;
      if (push) begin
        b.data = i_data_i[g*8 +: 8];
        b.last = i_last_i[g];
        b.src  = 2'(g);
        exp_q.push_back(b);
`ifdef RR_ARB_LOCK_EN
        if (i_last_i[g]) begin
          m_ptr  = (g + 1) % 4;
          m_lock = 0;
        end else begin
          m_lock     = 1;
          m_lock_src = g;
        end
`else
        m_ptr = (g + 1) % 4;
`endif
      end
      m_cnt  = m_cnt + int'(push) - int'(pop);
      m_push = push;
      m_g    = g;
    end
  end

  // Monitor: compares egress against the scoreboard on each handshake.
  always @(posedge clk) begin : p_monitor
    beat_t b;
    #3;
    if (!reset) begin
      chk("egress_in_reset", {20'b0, e_valid_o, e_data_o, e_last_o, e_src_o}, 32'h0);
    end else begin
      chk("e_valid", {31'b0, e_valid_o}, {31'b0, exp_q.size() != 0});
      if (e_valid_o && e_ready_i && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("e_beat", {21'b0, e_data_o, e_last_o, e_src_o}, {21'b0, b});
        obs_src.push_back(int'(e_src_o));
        obs_data.push_back(int'(e_data_o));
        obs_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] v);
    tick();
    reset = 1'b0;
    i_valid_i = v;
    e_ready_i = 1'b1;
    tick();
    tick();
  endtask

  task automatic clear_obs();
    obs_src.delete();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  int exp_fair_d[5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
  int exp_fair_s[5] = '{0, 1, 2, 3, 0};
`ifdef RR_ARB_LOCK_EN
  int exp_lock_s[5] = '{2, 2, 2, 0, 0};
`else
  int exp_lock_s[5] = '{2, 0, 2, 0, 2};
`endif

  initial begin
    int idx;
    int b2;

    // ---------------- Reset + fairness ----------------
    do_reset(4'b1111);
    clear_obs();
    i_data_i = {8'h13, 8'h12, 8'h11, 8'h10};
    i_last_i = 4'b1111;
    reset = 1'b1;
    repeat (8) tick();
    i_valid_i = 4'b0;
    repeat (3) tick();
    chk("fair_count_ge5", {31'b0, obs_src.size() >= 5}, 32'h1);
    if (obs_src.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("fair_data", obs_data[k], exp_fair_d[k]);
        chk("fair_src", obs_src[k], exp_fair_s[k]);
        if (k > 0) chk("fair_consecutive", obs_cyc[k] - obs_cyc[k-1], 1);
      end
    end

    // ---------------- Backpressure ----------------
    do_reset(4'b0000);
    reset = 1'b1;
    clear_obs();
    idx = 0;
    for (int c = 1; c <= 14; c++) begin
      i_valid_i = (idx < 5) ? 4'b0010 : 4'b0000;
      i_data_i  = {16'h0, 8'(idx + 1), 8'h0};
      i_last_i  = 4'b1111;
      e_ready_i = !(c >= 2 && c <= 4);
      tick();
      if (m_push) idx++;
    end
    chk("bp_count", obs_data.size(), 5);
    for (int k = 0; k < 5 && k < obs_data.size(); k++) begin
      chk("bp_order", obs_data[k], k + 1);
    end

    // ---------------- Packet lock / interleave ----------------
    do_reset(4'b0000);
    reset = 1'b1;
    i_valid_i = 4'b0010;
    i_data_i  = {16'h0, 8'h77, 8'h0};
    i_last_i  = 4'b1111;
    tick();
    i_valid_i = 4'b0000;
    repeat (3) tick();
    clear_obs();
    b2 = 0;
    for (int c = 0; c < 12; c++) begin
      i_valid_i = {1'b0, (b2 < 3), 1'b0, 1'b1};
      i_data_i  = {8'h0, 8'(8'h20 + b2), 8'h0, 8'h40};
      i_last_i  = {1'b1, (b2 == 2), 1'b1, 1'b1};
      tick();
      if (m_push && m_g == 2) b2++;
    end
    i_valid_i = 4'b0000;
    repeat (3) tick();
    chk("lock_count_ge5", {31'b0, obs_src.size() >= 5}, 32'h1);
    for (int k = 0; k < 5 && k < obs_src.size(); k++) begin
      chk("lock_src", obs_src[k], exp_lock_s[k]);
    end

    // ---------------- Randomized ----------------
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
      end else begin
        reset = 1'b1;
      end
      i_valid_i = 4'($urandom);
      i_data_i  = $urandom;
      i_last_i  = 4'($urandom);
      e_ready_i = (c % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tick();
    end

    // Drain and confirm nothing is left outstanding.
    reset = 1'b1;
    i_valid_i = 4'b0000;
    e_ready_i = 1'b1;
    repeat (6) tick();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", {31'b0, e_valid_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_skid_arbiter.md
RR_SKID_ARBITER -- requirements
Module: rr_skid_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 8, payload width per requester.
REQ-002 SHALL have ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- i_valid_i  input  4  per-requester valid.
- i_data_i  input  4*DATA_W  requester k payload at bits [k*DATA_W +: DATA_W].
- i_last_i  input  4  per-requester end-of-packet flag.
- i_ready_o  output  4  per-requester ready; at most one bit high.
- e_ready_i  input  1  egress ready.
- e_valid_o  output  1  egress valid.
- e_data_o  output  DATA_W  egress payload.
- e_last_o  output  1  egress end-of-packet flag.
- e_src_o  output  2  index of the requester that supplied the current egress beat.

Function
REQ-003 SHALL share one egress stream among 4 requesters with round-robin arbitration and a 2-entry output buffer (main, skid).
REQ-004 Buffer state SHALL be one of EMPTY (0 entries), HALF (1 entry), FULL (2 entries).
REQ-005 accept SHALL be (state != FULL); no input SHALL be taken in FULL.
REQ-006 Grant g SHALL be the first requester with i_valid_i high, searching from ptr upward modulo 4; ptr is a 2-bit round-robin pointer.
REQ-007 i_ready_o[g] SHALL be accept when any valid is high; all other bits SHALL be 0.
- i_ready_o SHALL depend only on state, ptr and i_valid_i, never on e_ready_i.
REQ-008 push SHALL be i_valid_i[g] & i_ready_o[g]; pop SHALL be e_valid_o & e_ready_i.
REQ-009 On push, {data, last, g} SHALL be captured.
- ptr SHALL become (g+1) mod 4.
REQ-010 e_valid_o SHALL be (state != EMPTY); e_data_o, e_last_o and e_src_o SHALL be driven from main.
REQ-011 Latency SHALL be 1 cycle: a beat pushed at edge N is visible on e_* after edge N.
REQ-012 State transitions SHALL be:
- EMPTY: push -> HALF, main <= in.
- HALF: push & !pop -> FULL, skid <= in.
- HALF: pop & !push -> EMPTY.
- HALF: push & pop -> HALF, main <= in.
- FULL: pop -> HALF, main <= skid.
- All other cases SHALL hold state and contents.
REQ-013 Sustained throughput SHALL be 1 beat/cycle while e_ready_i is high.
REQ-014 No beat SHALL be dropped or duplicated.
- Egress order SHALL equal push order.
REQ-015 When no i_valid_i bit is high, ptr and buffer contents SHALL hold.
REQ-016 Dropping a valid without a push SHALL NOT be treated as an error; the arbiter re-evaluates each cycle.

Reset
REQ-017 While reset is low, the block SHALL be asynchronously cleared:
- state = EMPTY, ptr = 0, main = 0, skid = 0.
- e_valid_o = 0, e_data_o = 0, e_last_o = 0, e_src_o = 0, i_ready_o = 0.
REQ-018 Reset asserted mid-packet or in FULL SHALL discard all buffered beats.
- Operation SHALL resume from requester 0 priority on the first edge after reset deasserts.
REQ-019 i_ready_o SHALL be forced to 0 while reset is low.

Configuration
REQ-020 Macro RR_ARB_LOCK_EN SHALL select packet-lock arbitration.
REQ-021 With RR_ARB_LOCK_EN defined:
- After a push with i_last_i[g] = 0, grant SHALL stay locked to g until a push from g with i_last_i[g] = 1.
- ptr SHALL advance only on that last beat.
- Other requesters SHALL see i_ready_o = 0 during lock.
- Reset SHALL clear the lock.
REQ-022 With RR_ARB_LOCK_EN undefined:
- Arbitration SHALL be per beat as in REQ-006.
- i_last_i SHALL only be carried to e_last_o.

Verification
REQ-023 The bench SHALL cover:
- Reset: reset=0 with i_valid_i=4'b1111 -> i_ready_o=0, e_valid_o=0; reset=1 -> first beat granted to requester 0, e_src_o=0 one cycle later.
- Fairness: i_valid_i=4'b1111, e_ready_i=1, data k=8'h10+k -> e_data_o sequence 10,11,12,13,10 on consecutive cycles, e_src_o 0,1,2,3,0.
- Backpressure: one requester streams 8'h01..8'h05, e_ready_i=0 for cycles 2-4 -> state FULL after 2 pushes, i_ready_o=0 in FULL, egress 01..05 in order with no loss.
- Simultaneous push/pop in HALF: state stays HALF, main updated, throughput 1 beat/cycle.
- Lock (RR_ARB_LOCK_EN): requester 2 sends 3-beat packet (last on beat 3) while requester 0 valid -> e_src_o 2,2,2 then 0.
- Same stimulus without RR_ARB_LOCK_EN -> e_src_o alternates 2,0,2,0,2.
